// File: rtl/cache_write_buffer.sv
// -----------------------------------------------------------------------------
// cache_write_buffer
//
// Posted-write FIFO between a cache core and a downstream AXI-style write
// channel. The core pushes one word (address, data, byte strobes) per cycle.
// The head entry is presented downstream and is popped only once its write
// has completed. While the head write is in flight, the entry still counts in
// the level, so the buffer reports empty only after every write has finished.
//
// Ports
//   clk         in   clock, rising-edge active
//   reset       in   asynchronous, active-high reset
//   push        in   write request from the cache core
//   push_addr   in   word address [FE_ADDR_W-1:FE_BYTE_W]
//   push_wdata  in   write data
//   push_wstrb  in   byte strobes
//   full        out  buffer holds 2**DEPTH_W entries
//   empty       out  nothing stored or in flight
//   level       out  number of stored entries, in-flight head included
//   mem_valid   out  request to the downstream write channel
//   mem_addr    out  head entry address
//   mem_wdata   out  head entry data
//   mem_wstrb   out  head entry strobes
//   mem_ready   in   downstream ready: accept when idle, one-cycle pulse on
//                    a successful write response
// -----------------------------------------------------------------------------
module cache_write_buffer #(
  parameter int FE_ADDR_W = 32,
  parameter int FE_DATA_W = 32,
  parameter int FE_NBYTES = FE_DATA_W / 8,
  parameter int FE_BYTE_W = $clog2(FE_NBYTES),
  parameter int DEPTH_W   = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [FE_ADDR_W-FE_BYTE_W-1:0] push_addr,
  input  logic [FE_DATA_W-1:0]       push_wdata,
  input  logic [FE_NBYTES-1:0]       push_wstrb,
  output logic                       full,
  output logic                       empty,
  output logic [DEPTH_W:0]           level,
  output logic                       mem_valid,
  output logic [FE_ADDR_W-FE_BYTE_W-1:0] mem_addr,
  output logic [FE_DATA_W-1:0]       mem_wdata,
  output logic [FE_NBYTES-1:0]       mem_wstrb,
  input  logic                       mem_ready
);

  localparam int AW    = FE_ADDR_W - FE_BYTE_W;
  localparam int DEPTH = 1 << DEPTH_W;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  localparam logic [DEPTH_W:0]   LVL_ONE  = 1;
  localparam logic [DEPTH_W:0]   LVL_TWO  = 2;
  localparam logic [DEPTH_W:0]   LVL_FULL = {1'b1, {DEPTH_W{1'b0}}};
  localparam logic [DEPTH_W-1:0] PTR_ONE  = 1;

  logic [0:0]         state_q, state_d;
  logic [DEPTH_W-1:0] head_q, head_d;
  logic [DEPTH_W-1:0] tail_q, tail_d;
  logic [DEPTH_W:0]   level_q, level_d;

  logic [AW-1:0]        addr_mem  [DEPTH];
  logic [FE_DATA_W-1:0] wdata_mem [DEPTH];
  logic [FE_NBYTES-1:0] wstrb_mem [DEPTH];

  logic push_acc;
  logic pop;
  logic two_or_more;

  assign full        = (level_q == LVL_FULL);
  assign empty       = (level_q == '0);
  assign level       = level_q;
  assign two_or_more = (level_q >= LVL_TWO);

  // Full is taken from the pre-edge level, so a slot freed by a completion
  // in this same cycle cannot be refilled until the next cycle.
  assign push_acc = push & ~full;
  // Only a ready seen while a write is in flight is a completion.
  assign pop      = (state_q == BUSY) & mem_ready;

  assign mem_addr  = addr_mem[head_q];
  assign mem_wdata = wdata_mem[head_q];
  assign mem_wstrb = wstrb_mem[head_q];

  // In BUSY the head is already in flight; mem_valid then announces that a
  // further entry will be ready to go the moment the head completes.
  always_comb begin
    mem_valid = 1'b0;
    state_d   = state_q;
    case (state_q)
      IDLE: begin
        mem_valid = ~empty;
        if (~empty && mem_ready) begin
          state_d = BUSY;
        end
      end
      BUSY: begin
        mem_valid = two_or_more;
        if (mem_ready) begin
          state_d = two_or_more ? BUSY : IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    level_d = level_q;
    if (push_acc) begin
      tail_d = tail_q + PTR_ONE;
    end
    if (pop) begin
      head_d = head_q + PTR_ONE;
    end
    case ({push_acc, pop})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
  end

  // Reset is expected to be released synchronously to clk by the
  // surrounding reset network; assertion takes effect immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      head_q  <= '0;
      tail_q  <= '0;
      level_q <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      level_q <= level_d;
    end
  end

  // Storage is deliberately left unreset; its contents are only observed
  // through the head while the buffer is non-empty.
  always_ff @(posedge clk) begin
    if (push_acc) begin
      addr_mem[tail_q]  <= push_addr;
      wdata_mem[tail_q] <= push_wdata;
      wstrb_mem[tail_q] <= push_wstrb;
    end
  end

endmodule

// File: tb/tb_cache_write_buffer.sv
module tb_cache_write_buffer;

  localparam int FE_ADDR_W = 32;
  localparam int FE_DATA_W = 32;
  localparam int FE_NBYTES = 4;
  localparam int FE_BYTE_W = 2;
  localparam int DEPTH_W   = 4;
  localparam int AW        = FE_ADDR_W - FE_BYTE_W;

  logic                 clk;
  logic                 reset;
  logic                 push;
  logic [AW-1:0]        push_addr;
  logic [FE_DATA_W-1:0] push_wdata;
  logic [FE_NBYTES-1:0] push_wstrb;
  logic                 full;
  logic                 empty;
  logic [DEPTH_W:0]     level;
  logic                 mem_valid;
  logic [AW-1:0]        mem_addr;
  logic [FE_DATA_W-1:0] mem_wdata;
  logic [FE_NBYTES-1:0] mem_wstrb;
  logic                 mem_ready;

  int vectors;
  int miscompares;

  cache_write_buffer #(
    .FE_ADDR_W(FE_ADDR_W),
    .FE_DATA_W(FE_DATA_W),
    .FE_NBYTES(FE_NBYTES),
    .FE_BYTE_W(FE_BYTE_W),
    .DEPTH_W  (DEPTH_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_addr (push_addr),
    .push_wdata(push_wdata),
    .push_wstrb(push_wstrb),
    .full      (full),
    .empty     (empty),
    .level     (level),
    .mem_valid (mem_valid),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_ready (mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled at the negedge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive_push(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s);
    push       = 1'b1;
    push_addr  = a;
    push_wdata = d;
    push_wstrb = s;
  endtask

  logic [AW-1:0] exp_addr [3];

  initial begin
    #20000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    push        = 1'b0;
    push_addr   = '0;
    push_wdata  = '0;
    push_wstrb  = '0;
    mem_ready   = 1'b0;
    step();
    step();
    reset = 1'b0;
    step();

    // Reset state
    check("rst_level", 64'(level), 64'd0);
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_full", 64'(full), 64'd0);
    check("rst_valid", 64'(mem_valid), 64'd0);

    // Single write: push, accept, complete three cycles later
    mem_ready = 1'b1;
    drive_push(30'h40, 32'hDEADBEEF, 4'hF);
    step();
    push = 1'b0;
    check("s1_level1", 64'(level), 64'd1);
    check("s1_valid", 64'(mem_valid), 64'd1);
    check("s1_addr", 64'(mem_addr), 64'h40);
    check("s1_wdata", 64'(mem_wdata), 64'hDEADBEEF);
    check("s1_wstrb", 64'(mem_wstrb), 64'hF);
    step();
    mem_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      check("s1_busy_valid", 64'(mem_valid), 64'd0);
      check("s1_busy_addr", 64'(mem_addr), 64'h40);
      check("s1_busy_wdata", 64'(mem_wdata), 64'hDEADBEEF);
      step();
    end
    check("s1_busy_level", 64'(level), 64'd1);
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    check("s1_done_level", 64'(level), 64'd0);
    check("s1_done_empty", 64'(empty), 64'd1);
    check("s1_done_valid", 64'(mem_valid), 64'd0);

    // Three back-to-back pushes, completion every fourth cycle
    exp_addr[0] = 30'h111;
    exp_addr[1] = 30'h222;
    exp_addr[2] = 30'h333;
    for (int i = 0; i < 3; i++) begin
      drive_push(exp_addr[i], 32'hA0 + 32'(i), 4'h1 << i);
      step();
    end
    push = 1'b0;
    check("s2_level3", 64'(level), 64'd3);
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      step();
      step();
      check("s2_cpl_addr", 64'(mem_addr), 64'(exp_addr[i]));
      check("s2_cpl_wdata", 64'(mem_wdata), 64'hA0 + 64'(i));
      check("s2_cpl_valid", 64'(mem_valid), (i < 2) ? 64'd1 : 64'd0);
      mem_ready = 1'b1;
      step();
      mem_ready = 1'b0;
      check("s2_cpl_level", 64'(level), 64'(2 - i));
    end
    check("s2_end_empty", 64'(empty), 64'd1);
    check("s2_end_valid", 64'(mem_valid), 64'd0);

    // Fill to capacity, push while full, drain in order
    for (int i = 0; i < 16; i++) begin
      drive_push(30'(i), 32'h1000 + 32'(i), 4'(i));
      step();
    end
    check("s3_full", 64'(full), 64'd1);
    check("s3_level16", 64'(level), 64'd16);
    drive_push(30'h3FF, 32'hBADBAD, 4'hF);
    mem_ready = 1'b1;
    step();
    check("s3_drop_level", 64'(level), 64'd16);
    check("s3_head0_addr", 64'(mem_addr), 64'd0);
    step();
    push = 1'b0;
    check("s3_drop_on_pop_level", 64'(level), 64'd15);
    check("s3_notfull", 64'(full), 64'd0);
    for (int i = 1; i < 16; i++) begin
      check("s3_drain_addr", 64'(mem_addr), 64'(i));
      check("s3_drain_wdata", 64'(mem_wdata), 64'h1000 + 64'(i));
      check("s3_drain_wstrb", 64'(mem_wstrb), 64'(i));
      step();
    end
    mem_ready = 1'b0;
    check("s3_end_level", 64'(level), 64'd0);
    check("s3_end_empty", 64'(empty), 64'd1);

    // Push coincident with completion at level 1
    drive_push(30'h0AA, 32'h55, 4'h3);
    step();
    push = 1'b0;
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    step();
    drive_push(30'h0BB, 32'h66, 4'hC);
    mem_ready = 1'b1;
    #1;
    check("s4_coinc_valid", 64'(mem_valid), 64'd0);
    step();
    push = 1'b0;
    mem_ready = 1'b0;
    check("s4_after_level", 64'(level), 64'd1);
    check("s4_after_valid", 64'(mem_valid), 64'd1);
    check("s4_after_addr", 64'(mem_addr), 64'h0BB);
    check("s4_after_wstrb", 64'(mem_wstrb), 64'hC);
    mem_ready = 1'b1;
    step();
    step();
    mem_ready = 1'b0;
    check("s4_end_empty", 64'(empty), 64'd1);

    // Reset while BUSY with five entries
    for (int i = 0; i < 5; i++) begin
      drive_push(30'h500 + 30'(i), 32'h500 + 32'(i), 4'hF);
      step();
    end
    push = 1'b0;
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    check("s5_pre_level", 64'(level), 64'd5);
    check("s5_pre_valid", 64'(mem_valid), 64'd1);
    reset = 1'b1;
    #1;
    check("s5_rst_level", 64'(level), 64'd0);
    check("s5_rst_empty", 64'(empty), 64'd1);
    check("s5_rst_valid", 64'(mem_valid), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    drive_push(30'h777, 32'hCAFEF00D, 4'h5);
    step();
    push = 1'b0;
    check("s5_new_valid", 64'(mem_valid), 64'd1);
    check("s5_new_addr", 64'(mem_addr), 64'h777);
    check("s5_new_wdata", 64'(mem_wdata), 64'hCAFEF00D);
    mem_ready = 1'b1;
    step();
    check("s5_new_busy_valid", 64'(mem_valid), 64'd0);
    step();
    mem_ready = 1'b0;
    check("s5_new_done_empty", 64'(empty), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
